// File: rtl/nibble_assembler.sv
// Rebuilds MSB-first words from a nibble stream framed by a first-nibble marker,
// buffers finished words in a small show-ahead FIFO and flags framing errors and drops.
module nibble_assembler #(
    parameter int NIB_W      = 4,
    parameter int NIBBLES    = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NIB_W-1:0]         in,
    input  logic                     trig,
    output logic [NIB_W*NIBBLES-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     sync_err,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int W   = NIB_W * NIBBLES;
    localparam int CW  = $clog2(NIBBLES + 1);
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW = AW + 1;
    localparam logic [CW-1:0]  LAST_IDX  = CW'(NIBBLES - 1);
    localparam logic [FCW-1:0] FIFO_FULL = FCW'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    sr_q, sr_d;
    logic            push_s;
    logic            sync_err_q, sync_err_d;

    logic [W-1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FCW-1:0]  fcnt_q, fcnt_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic            pop_s, full_s, wr_en_s, drop_s;

    // Framing FSM: next state, shift-register contents and word-complete strobe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        push_s     = 1'b0;
        sync_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    sr_d              = {W{1'b0}};
                    sr_d[W-1 -: NIB_W] = in;
                    cnt_d             = CW'(1);
                    state_d           = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (trig) begin
                    // A marker mid-word restarts framing; the partial word is lost.
                    sync_err_d         = 1'b1;
                    sr_d               = {W{1'b0}};
                    sr_d[W-1 -: NIB_W] = in;
                    cnt_d              = CW'(1);
                end else begin
                    for (int k = 0; k < NIBBLES; k++) begin
                        if (cnt_q == CW'(k)) begin
                            sr_d[W-1-k*NIB_W -: NIB_W] = in;
                        end else begin
                            sr_d[W-1-k*NIB_W -: NIB_W] = sr_d[W-1-k*NIB_W -: NIB_W];
                        end
                    end
                    if (cnt_q == LAST_IDX) begin
                        push_s  = 1'b1;
                        cnt_d   = {CW{1'b0}};
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Framing state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CW{1'b0}};
            sr_q       <= {W{1'b0}};
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            sync_err_q <= sync_err_d;
        end
    end

    // FIFO control: accept a push when full only if the head leaves in the same cycle.
    always_comb begin
        pop_s   = out_valid_q && out_ready;
        full_s  = (fcnt_q == FIFO_FULL);
        wr_en_s = push_s && (!full_s || pop_s);
        drop_s  = push_s && full_s && !pop_s;

        wr_ptr_d = wr_en_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s   ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        case ({wr_en_s, pop_s})
            2'b10:   fcnt_d = fcnt_q + FCW'(1);
            2'b01:   fcnt_d = fcnt_q - FCW'(1);
            default: fcnt_d = fcnt_q;
        endcase

        out_valid_d = (fcnt_d != {FCW{1'b0}});
        // The next head may be the word being written this very cycle.
        if (!out_valid_d) begin
            out_data_d = {W{1'b0}};
        end else if (wr_en_s && (rd_ptr_d == wr_ptr_q)) begin
            out_data_d = sr_d;
        end else begin
            out_data_d = mem_q[rd_ptr_d];
        end

        overflow_d = drop_s;
        if (drop_s && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // FIFO storage, pointers and registered output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            fcnt_q      <= {FCW{1'b0}};
            out_data_q  <= {W{1'b0}};
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= sr_d;
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcnt_q      <= fcnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ST_COLLECT);
    assign sync_err  = sync_err_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/nibble_assembler.md
# nibble_assembler

Receive-side stage directly downstream of the nibble serializer. It consumes the 4-bit nibble stream and its first-nibble marker `trig`, and rebuilds each 24-bit word MSB-first. Completed words go into a small show-ahead FIFO and are handed to the decoder over a valid/ready handshake. The block also flags framing errors and dropped words.

## Interface
- `NIB_W`, 4, nibble width in bits.
- `NIBBLES`, 6, nibbles per word; word width = `NIB_W*NIBBLES` (24).
- `FIFO_DEPTH`, 2, output FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in`  in  `NIB_W`  nibble stream; sampled every cycle.
- `trig`  in  1  high for exactly the cycle that carries nibble 0 (bits 23:20).
- `out_data`  out  `NIB_W*NIBBLES`  FIFO head word; 0 when the FIFO is empty.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `busy`  out  1  a word is partially collected.
- `sync_err`  out  1  one-cycle pulse: `trig` arrived mid-word.
- `overflow`  out  1  one-cycle pulse: a completed word was dropped.
- `drop_cnt`  out  8  saturating count of dropped words.

## Operation
- Reset values: `out_data`=0, `out_valid`=0, `busy`=0, `sync_err`=0, `overflow`=0, `drop_cnt`=0. The FIFO is emptied, the shift register is zeroed and the state is IDLE.
- **IDLE**:
  - `trig`=1: load `in` as nibble 0, set count=1, go to COLLECT.
  - `trig`=0: the input is ignored; this includes the trailing zero nibble from upstream.
- **COLLECT**:
  - Every cycle, shift `in` into the next lower nibble position and increment count. Nibble k occupies bits `[W-1-k*NIB_W -: NIB_W]`.
  - When count reaches `NIBBLES`, the word is complete. Push it to the FIFO and return to IDLE.
  - If `trig`=1 while in COLLECT: pulse `sync_err`, discard the partial word, load `in` as the new nibble 0, set count=1, stay in COLLECT. This also applies when `trig` coincides with the would-be 6th nibble; that word is not pushed.
- `busy` = (state == COLLECT).
- **FIFO**:
  - Pop when `out_valid && out_ready`.
  - A push when full with no simultaneous pop: the word is dropped, `overflow` pulses, and `drop_cnt` increments, saturating at 255.
  - A push when full with a simultaneous pop is accepted; nothing is dropped.
  - A push and pop when empty is not possible, since `out_valid`=0.
  - Order is strictly FIFO; read and write pointers wrap modulo `FIFO_DEPTH`.
- `out_ready` while `out_valid`=0 has no effect.

## Timing
- `trig` sampled at edge T loads nibble 0. Nibbles 1..5 are sampled at edges T+1..T+5.
- The push happens at edge T+5. `out_valid` rises in the cycle after edge T+5 if the FIFO was empty (latency 6 cycles from `trig`).
- Back-to-back words are supported: `trig` at T+6 starts the next word with no gap.
- `sync_err` and `overflow` are registered and high for exactly one cycle after the triggering edge.
- `out_data` and `out_valid` update on the edge after a pop; a new head appears the next cycle.
- An asynchronous `reset` assertion mid-word or mid-handshake forces the reset values at once. Release is synchronous to `clk`, and the first `trig` can be accepted on the first edge after release.

## Test plan
- **Single word:** `trig`=1 with nibbles 0xA,0xB,0xC,0xD,0xE,0xF, `out_ready`=1 → `out_valid` for one cycle, 6 cycles after `trig`, with `out_data`=0xABCDEF. `sync_err`=0, `overflow`=0.
- **Back-to-back:** 0x123456 then 0x789ABC on consecutive frames, `out_ready`=1 → two words delivered in order, 6 cycles apart.
- **Resync:** `trig` with 1,2,3, then `trig` again with 4,5,6,7,8,9 → `sync_err` pulses once and only 0x456789 is delivered.
- **Overflow:** `out_ready`=0 for three frames 0x111111, 0x222222, 0x333333 → third push dropped, `overflow` pulse, `drop_cnt`=1. Then `out_ready`=1 drains 0x111111 then 0x222222.
- **Full + simultaneous pop:** FIFO holds 2 words, `out_ready`=1 at the completion edge of a third word → no drop, three words delivered in order, `drop_cnt` unchanged.
- **Reset mid-word:** assert `reset` after 3 nibbles, release, then send 0xFEDCBA → all outputs at reset values during `reset`, and only 0xFEDCBA is delivered.
